plane_move_ctrl: RTL and testbench

// - Consumes the encoded button interface (move_en + 2-bit direction) and drives the player plane position.
// - Synchronises the asynchronous pin-derived inputs.
// - Applies one step per press, then hold-to-repeat auto-stepping, paced by the frame tick.
// - Clamps the position to the playfield bounds. Feeds the sprite renderer and the collision logic.

---
 rtl/plane_move_ctrl_pkg.sv | 31 +++
 rtl/plane_move_ctrl_if.sv | 41 ++++
 rtl/plane_move_ctrl_sync_2ff.sv | 33 +++
 rtl/plane_move_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_plane_move_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/plane_move_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// plane_move_ctrl_pkg
// Shared types for the player-plane movement slice.
//   DIR_W   : width of the encoded direction field.
//   dir_t   : direction codes (LEFT=0, RIGHT=1, UP=2, DOWN=3).
//   state_t : movement FSM states.
//   max_u   : constant helper used to size the shared tick counter.
// ----------------------------------------------------------------------------
package plane_move_ctrl_pkg;

    localparam int unsigned DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/plane_move_ctrl_if.sv
// ----------------------------------------------------------------------------
// plane_move_ctrl_if
// Bundles the button-encoder / game-control inputs and the position outputs
// of the plane movement controller.
//   move_en_i    : move request from the button encoder (asynchronous)
//   direct_i     : direction code, valid while move_en_i=1 (asynchronous)
//   frame_tick_i : one-clk pulse per video frame
//   game_run_i   : 1 = gameplay active, 0 = freeze
//   restart_i    : one-clk pulse returning the plane to its start position
//   pos_x_o/pos_y_o : registered plane position
//   moving_o     : high for the clk after a step was applied
//   at_edge_o    : high while held against the playfield bound
// master drives the requests, slave is the controller.
// ----------------------------------------------------------------------------
interface plane_move_ctrl_if #(
    parameter int unsigned X_W = 10,
    parameter int unsigned Y_W = 10
);
    import plane_move_ctrl_pkg::*;

    logic             move_en_i;
    logic [DIR_W-1:0] direct_i;
    logic             frame_tick_i;
    logic             game_run_i;
    logic             restart_i;
    logic [X_W-1:0]   pos_x_o;
    logic [Y_W-1:0]   pos_y_o;
    logic             moving_o;
    logic             at_edge_o;

    modport master (
        output move_en_i, direct_i, frame_tick_i, game_run_i, restart_i,
        input  pos_x_o, pos_y_o, moving_o, at_edge_o
    );

    modport slave (
        input  move_en_i, direct_i, frame_tick_i, game_run_i, restart_i,
        output pos_x_o, pos_y_o, moving_o, at_edge_o
    );

endinterface

// File: rtl/plane_move_ctrl_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for W asynchronous bits, async active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   i_d   : asynchronous input bits
//   o_q   : synchronised output (2 clk latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/plane_move_ctrl.sv
// ----------------------------------------------------------------------------
// plane_move_ctrl
// Drives the player plane position from the encoded buttons: one step per
// press, then hold-to-repeat auto-stepping paced by the frame tick, with the
// position clamped to the playfield.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   ctrl_bus : plane_move_ctrl_if.slave (requests in, position/status out)
// ----------------------------------------------------------------------------
module plane_move_ctrl
    import plane_move_ctrl_pkg::*;
#(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 607,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = 447,
    parameter int unsigned X_INIT     = 304,
    parameter int unsigned Y_INIT     = 400,
    parameter int unsigned STEP       = 4,
    parameter int unsigned HOLD_DLY   = 8,
    parameter int unsigned REPEAT_PER = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    plane_move_ctrl_if.slave   ctrl_bus
);

    localparam int unsigned CNT_MAX = max_u(HOLD_DLY, REPEAT_PER);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_DLY - 1);
    localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'(REPEAT_PER - 1);

    // Clamp constants at X_W+1 / Y_W+1 bits so the step arithmetic never wraps.
    localparam logic [X_W:0] C_X_MIN  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0] C_X_MAX  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0] C_X_STEP = (X_W+1)'(STEP);
    localparam logic [X_W:0] C_X_LO   = (X_W+1)'(X_MIN + STEP);
    localparam logic [X_W:0] C_X_HI   = (X_W+1)'(X_MAX - STEP);
    localparam logic [Y_W:0] C_Y_MIN  = (Y_W+1)'(Y_MIN);
    localparam logic [Y_W:0] C_Y_MAX  = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0] C_Y_STEP = (Y_W+1)'(STEP);
    localparam logic [Y_W:0] C_Y_LO   = (Y_W+1)'(Y_MIN + STEP);
    localparam logic [Y_W:0] C_Y_HI   = (Y_W+1)'(Y_MAX - STEP);

    logic [DIR_W:0]   w_sync_in;
    logic [DIR_W:0]   w_sync_out;
    logic             w_en;
    dir_t             w_dir;

    logic [X_W:0]     w_x_ext;
    logic [Y_W:0]     w_y_ext;
    logic [X_W:0]     w_x_sum;
    logic [Y_W:0]     w_y_sum;
    logic             w_at_bound;

    state_t           r_state;
    dir_t             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_pos_x;
    logic [Y_W-1:0]   r_pos_y;
    logic             r_moving;
    logic             r_at_edge;

    assign w_sync_in = {ctrl_bus.move_en_i, ctrl_bus.direct_i};

    sync_2ff #(.W(DIR_W + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_sync_in),
        .o_q   (w_sync_out)
    );

    assign w_en  = w_sync_out[DIR_W];
    assign w_dir = dir_t'(w_sync_out[DIR_W-1:0]);

    assign w_x_ext = {1'b0, r_pos_x};
    assign w_y_ext = {1'b0, r_pos_y};

    // Candidate position for a step in the synced direction, plus bound test.
    always_comb begin
        w_x_sum    = w_x_ext;
        w_y_sum    = w_y_ext;
        w_at_bound = 1'b0;
        case (w_dir)
            DIR_LEFT: begin
                w_x_sum    = (w_x_ext < C_X_LO) ? C_X_MIN : (w_x_ext - C_X_STEP);
                w_at_bound = (w_x_ext == C_X_MIN);
            end
            DIR_RIGHT: begin
                w_x_sum    = (w_x_ext > C_X_HI) ? C_X_MAX : (w_x_ext + C_X_STEP);
                w_at_bound = (w_x_ext == C_X_MAX);
            end
            DIR_UP: begin
                w_y_sum    = (w_y_ext < C_Y_LO) ? C_Y_MIN : (w_y_ext - C_Y_STEP);
                w_at_bound = (w_y_ext == C_Y_MIN);
            end
            DIR_DOWN: begin
                w_y_sum    = (w_y_ext > C_Y_HI) ? C_Y_MAX : (w_y_ext + C_Y_STEP);
                w_at_bound = (w_y_ext == C_Y_MAX);
            end
        endcase
    end

    // The counter restarts at 0 on the PRESS step so that HOLD's last count
    // (HOLD_DLY-1) lands exactly HOLD_DLY ticks after the first step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dir     <= DIR_LEFT;
            r_cnt     <= '0;
            r_pos_x   <= X_W'(X_INIT);
            r_pos_y   <= Y_W'(Y_INIT);
            r_moving  <= 1'b0;
            r_at_edge <= 1'b0;
        end else begin
            r_moving  <= 1'b0;
            r_at_edge <= w_en && w_at_bound;
            if (ctrl_bus.restart_i) begin
                r_pos_x <= X_W'(X_INIT);
                r_pos_y <= Y_W'(Y_INIT);
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (!ctrl_bus.game_run_i || !w_en) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (r_state != ST_IDLE && w_dir != r_dir) begin
                // A new direction restarts the press sequence, even on a tick.
                r_state <= ST_PRESS;
                r_dir   <= w_dir;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_PRESS;
                        r_dir   <= w_dir;
                        r_cnt   <= '0;
                    end
                    ST_PRESS: begin
                        if (ctrl_bus.frame_tick_i) begin
                            r_pos_x  <= w_x_sum[X_W-1:0];
                            r_pos_y  <= w_y_sum[Y_W-1:0];
                            r_moving <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (ctrl_bus.frame_tick_i) begin
                            if (r_cnt == C_HOLD_LAST) begin
                                r_pos_x  <= w_x_sum[X_W-1:0];
                                r_pos_y  <= w_y_sum[Y_W-1:0];
                                r_moving <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= ST_REPEAT;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (ctrl_bus.frame_tick_i) begin
                            if (r_cnt == C_REP_LAST) begin
                                r_pos_x  <= w_x_sum[X_W-1:0];
                                r_pos_y  <= w_y_sum[Y_W-1:0];
                                r_moving <= 1'b1;
                                r_cnt    <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign ctrl_bus.pos_x_o   = r_pos_x;
    assign ctrl_bus.pos_y_o   = r_pos_y;
    assign ctrl_bus.moving_o  = r_moving;
    assign ctrl_bus.at_edge_o = r_at_edge;

endmodule

// File: tb/tb_plane_move_ctrl.sv
// ----------------------------------------------------------------------------
// tb_plane_move_ctrl
// Directed bench for plane_move_ctrl with hand-computed expected positions.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_plane_move_ctrl;
    import plane_move_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    plane_move_ctrl_if #(.X_W(10), .Y_W(10)) bus ();

    plane_move_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl_bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One frame tick; returns on the falling edge after the tick was sampled.
    task automatic do_tick();
        @(negedge clk);
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
    endtask

    // Pin change plus synchroniser and IDLE->PRESS latency.
    task automatic press(input dir_t d);
        bus.direct_i  = d;
        bus.move_en_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic release_btn();
        bus.move_en_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tap(input dir_t d);
        press(d);
        do_tick();
        release_btn();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic exp_mv;

        bus.move_en_i    = 1'b0;
        bus.direct_i     = '0;
        bus.frame_tick_i = 1'b0;
        bus.game_run_i   = 1'b1;
        bus.restart_i    = 1'b0;
        rst_n            = 1'b0;

        // T1: reset with toggling inputs, then idle ticks.
        repeat (6) begin
            @(negedge clk);
            bus.move_en_i    = 1'($urandom_range(0, 1));
            bus.direct_i     = 2'($urandom_range(0, 3));
            bus.frame_tick_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_x", bus.pos_x_o, 304);
        check("rst_y", bus.pos_y_o, 400);
        check("rst_mv", bus.moving_o, 0);
        check("rst_edge", bus.at_edge_o, 0);
        bus.move_en_i    = 1'b0;
        bus.direct_i     = '0;
        bus.frame_tick_i = 1'b0;
        rst_n            = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            do_tick();
            check("idle_mv", bus.moving_o, 0);
        end
        check("idle_x", bus.pos_x_o, 304);
        check("idle_y", bus.pos_y_o, 400);

        // T2: single RIGHT tap.
        press(DIR_RIGHT);
        do_tick();
        check("tap_x", bus.pos_x_o, 308);
        check("tap_mv", bus.moving_o, 1);
        @(negedge clk);
        check("tap_mv_off", bus.moving_o, 0);
        release_btn();
        do_tick();
        check("tap_x_after", bus.pos_x_o, 308);
        check("tap_mv_after", bus.moving_o, 0);

        // T3: UP held 20 ticks -> steps at T0,T8,T10,..,T18.
        press(DIR_UP);
        for (int k = 0; k < 20; k++) begin
            do_tick();
            exp_mv = (k == 0) || (k == 8) || (k > 8 && (k % 2) == 0);
            check($sformatf("hold_mv_T%0d", k), bus.moving_o, exp_mv);
        end
        check("hold_y", bus.pos_y_o, 372);
        check("hold_x", bus.pos_x_o, 308);
        release_btn();

        // T4: right bound (604 -> 607 clamped), then left bound (3 -> 0).
        for (int i = 0; i < 74; i++) tap(DIR_RIGHT);
        check("clampR_pre", bus.pos_x_o, 604);
        tap(DIR_RIGHT);
        check("clampR_x", bus.pos_x_o, 607);
        press(DIR_RIGHT);
        do_tick();
        check("clampR_x2", bus.pos_x_o, 607);
        check("clampR_mv", bus.moving_o, 1);
        check("clampR_edge", bus.at_edge_o, 1);
        release_btn();
        check("clampR_edge_off", bus.at_edge_o, 0);
        for (int i = 0; i < 151; i++) tap(DIR_LEFT);
        check("clampL_pre", bus.pos_x_o, 3);
        tap(DIR_LEFT);
        check("clampL_x", bus.pos_x_o, 0);
        press(DIR_LEFT);
        do_tick();
        check("clampL_x2", bus.pos_x_o, 0);
        check("clampL_mv", bus.moving_o, 1);
        check("clampL_edge", bus.at_edge_o, 1);
        release_btn();

        // T5: RIGHT into REPEAT, switch to DOWN.
        press(DIR_RIGHT);
        for (int k = 0; k < 10; k++) do_tick();
        check("dc_x_repeat", bus.pos_x_o, 8);
        bus.direct_i = DIR_DOWN;
        repeat (4) @(negedge clk);
        check("dc_x_hold", bus.pos_x_o, 8);
        check("dc_y_hold", bus.pos_y_o, 372);
        do_tick();
        check("dc_y_first", bus.pos_y_o, 376);
        check("dc_mv_first", bus.moving_o, 1);
        pulses = 0;
        for (int k = 1; k < 8; k++) begin
            do_tick();
            if (bus.moving_o) pulses++;
        end
        check("dc_quiet", pulses, 0);
        do_tick();
        check("dc_y_second", bus.pos_y_o, 380);
        check("dc_mv_second", bus.moving_o, 1);
        check("dc_x_final", bus.pos_x_o, 8);
        release_btn();

        // T6a: restart coincident with a step tick.
        press(DIR_LEFT);
        @(negedge clk);
        bus.frame_tick_i = 1'b1;
        bus.restart_i    = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        bus.restart_i    = 1'b0;
        check("rs_x", bus.pos_x_o, 304);
        check("rs_y", bus.pos_y_o, 400);
        check("rs_mv", bus.moving_o, 0);
        release_btn();

        // T6b: frozen game ignores a held button.
        bus.game_run_i = 1'b0;
        press(DIR_LEFT);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            if (bus.moving_o) pulses++;
        end
        check("frz_mv", pulses, 0);
        check("frz_x", bus.pos_x_o, 304);
        check("frz_y", bus.pos_y_o, 400);
        release_btn();
        bus.game_run_i = 1'b1;

        // T6c: reset mid-REPEAT, button still held.
        press(DIR_RIGHT);
        for (int k = 0; k < 9; k++) do_tick();
        check("rr_x_pre", bus.pos_x_o, 312);
        check("rr_mv_pre", bus.moving_o, 1);
        rst_n = 1'b0;
        #1;
        check("rr_x", bus.pos_x_o, 304);
        check("rr_y", bus.pos_y_o, 400);
        check("rr_mv", bus.moving_o, 0);
        check("rr_edge", bus.at_edge_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_tick();
        check("rr_x_post", bus.pos_x_o, 308);
        check("rr_mv_post", bus.moving_o, 1);
        release_btn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
